// File: rtl/pulse_burst_gen.sv
// ---------------------------------------------------------------------------
// pulse_burst_gen : programmable burst of N pulses, H cycles high, L cycles low
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module pulse_burst_gen #(
  parameter int MAX_PULSES = 8,
  parameter int PH_W       = 8,
  localparam int CNT_W     = $clog2(MAX_PULSES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] n_pulses,
  input  logic [PH_W-1:0]  high_cyc,
  input  logic [PH_W-1:0]  low_cyc,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_PULSES);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [PH_W-1:0]  c_ph_one  = PH_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Power-up values match the reset values.
  state_t           r_state   = ST_IDLE;
  logic [PH_W-1:0]  r_ph_cnt  = '0;
  logic [PH_W-1:0]  r_h_lat   = '0;
  logic [PH_W-1:0]  r_l_lat   = '0;
  logic [CNT_W-1:0] r_n_lat   = '0;
  logic [CNT_W-1:0] r_sent    = '0;
  logic             r_at_max  = 1'b0;
  logic             r_pulse   = 1'b0;
  logic             r_busy    = 1'b0;
  logic             r_done    = 1'b0;

  state_t           w_state;
  logic [PH_W-1:0]  w_ph_cnt;
  logic [PH_W-1:0]  w_h_lat;
  logic [PH_W-1:0]  w_l_lat;
  logic [CNT_W-1:0] w_n_lat;
  logic [CNT_W-1:0] w_sent;
  logic             w_at_max;
  logic             w_pulse;
  logic             w_busy;
  logic             w_done;

  logic [PH_W-1:0]  w_h_in;
  logic [PH_W-1:0]  w_l_in;
  logic [CNT_W-1:0] w_n_in;
  logic             w_clamp;

  assign w_h_in  = (high_cyc == '0) ? c_ph_one : high_cyc;
  assign w_l_in  = (low_cyc  == '0) ? c_ph_one : low_cyc;
  assign w_clamp = (n_pulses > c_max_cnt);
  assign w_n_in  = w_clamp ? c_max_cnt : n_pulses;

  // Phase counter holds the cycles still to go in the current phase after
  // this one, so a phase of length P loads P-1 and ends when it reads zero.
  always_comb begin
    w_state  = r_state;
    w_ph_cnt = r_ph_cnt;
    w_h_lat  = r_h_lat;
    w_l_lat  = r_l_lat;
    w_n_lat  = r_n_lat;
    w_sent   = r_sent;
    w_at_max = r_at_max;
    w_pulse  = r_pulse;
    w_busy   = r_busy;
    w_done   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_pulse = 1'b0;
        w_busy  = 1'b0;
        if (start && !abort) begin
          w_h_lat  = w_h_in;
          w_l_lat  = w_l_in;
          w_n_lat  = w_n_in;
          w_at_max = w_clamp;
          if (w_n_in == '0) begin
            w_sent  = '0;
            w_state = ST_DONE;
            w_done  = 1'b1;
          end else begin
            w_sent   = c_cnt_one;
            w_state  = ST_HIGH;
            w_pulse  = 1'b1;
            w_busy   = 1'b1;
            w_ph_cnt = w_h_in - c_ph_one;
          end
        end
      end

      ST_HIGH: begin
        if (abort) begin
          w_state = ST_IDLE;
          w_pulse = 1'b0;
          w_busy  = 1'b0;
        end else if (r_ph_cnt != '0) begin
          w_ph_cnt = r_ph_cnt - c_ph_one;
        end else if (r_sent != r_n_lat) begin
          w_state  = ST_LOW;
          w_pulse  = 1'b0;
          w_ph_cnt = r_l_lat - c_ph_one;
        end else begin
          w_state = ST_DONE;
          w_pulse = 1'b0;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end
      end

      ST_LOW: begin
        if (abort) begin
          w_state = ST_IDLE;
          w_pulse = 1'b0;
          w_busy  = 1'b0;
        end else if (r_ph_cnt != '0) begin
          w_ph_cnt = r_ph_cnt - c_ph_one;
        end else begin
          w_state  = ST_HIGH;
          w_pulse  = 1'b1;
          w_sent   = r_sent + c_cnt_one;
          w_ph_cnt = r_h_lat - c_ph_one;
        end
      end

      ST_DONE: begin
        w_state = ST_IDLE;
        w_pulse = 1'b0;
        w_busy  = 1'b0;
      end

      default: begin
        w_state = ST_IDLE;
        w_pulse = 1'b0;
        w_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ph_cnt <= '0;
      r_h_lat  <= '0;
      r_l_lat  <= '0;
      r_n_lat  <= '0;
      r_sent   <= '0;
      r_at_max <= 1'b0;
      r_pulse  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_ph_cnt <= w_ph_cnt;
      r_h_lat  <= w_h_lat;
      r_l_lat  <= w_l_lat;
      r_n_lat  <= w_n_lat;
      r_sent   <= w_sent;
      r_at_max <= w_at_max;
      r_pulse  <= w_pulse;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

  assign pulse_out = r_pulse;
  assign busy      = r_busy;
  assign done      = r_done;
  assign sent      = r_sent;
  assign at_max    = r_at_max;

endmodule

`default_nettype wire
